link_rx_buffer: RTL and testbench
=================================

# link_rx_buffer

Receive-side buffer for one link of the instruction interconnect. It sits directly downstream of the master router and consumes one `check_*` / `*_instr` pair, either self, left or right. Each asserted `check` cycle captures one instruction word into a small first-word-fall-through FIFO. The FIFO is drained by the local node core through a valid/ready handshake; words that arrive while the FIFO is full are dropped and counted.

## Interface

Parameters:

- `width`, 32: instruction word width.
- `depth`, 4: FIFO entries. Must be a power of two, ≥ 2.
- `afull_level`, 3: occupancy at or above which `almost_full` asserts. Range 1..`depth`.

Ports:

- `clk`, input, 1: single clock. All state updates on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `check`, input, 1: word-present strobe from the router, one cycle per instruction.
- `in_instr`, input, `width`: instruction from the router. Valid only while `check` = 1; otherwise may be Z.
- `out_ready`, input, 1: consumer accepts the head word this cycle.
- `clear_ovf`, input, 1: clears `overflow` and `drop_count`.
- `out_valid`, output, 1: FIFO non-empty; `out_instr` holds the head word.
- `out_instr`, output, `width`: head word. Drives 0 when empty.
- `count`, output, clog2(`depth`)+1: current occupancy, 0..`depth`.
- `almost_full`, output, 1: `count` ≥ `afull_level`.
- `overflow`, output, 1: sticky flag; a word was dropped.
- `drop_count`, output, 8: dropped words. Saturates at 255.

## Operation

- Storage: `depth` × `width` memory, plus read pointer and write pointer of clog2(`depth`) bits each, plus `count`.
  - Pointers wrap modulo `depth`.
  - Full means `count` == `depth`; empty means `count` == 0.
- Push: `check` == 1 at the rising edge and (not full, or pop in the same cycle).
  - Writes `in_instr` at the write pointer and increments the write pointer.
- Any `check` value other than 1 is not a push. This includes X or Z.
- Pop: `out_valid` && `out_ready` at the rising edge. Increments the read pointer.
- `out_ready` while empty has no effect.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged.
- Full, pop, and push together: both proceed. `count` stays at `depth`, no drop.
- Full, push, and no pop: the word is discarded and pointers are unchanged.
  - `overflow` ← 1.
  - `drop_count` ← `drop_count`+1, holding at 255.
- Empty, push, and pop requested together: only the push occurs, because `out_valid` was 0 at that edge.
- `clear_ovf` == 1:
  - `overflow` ← 0 and `drop_count` ← 0.
  - If a drop happens in the same cycle, the drop wins: `overflow` = 1, `drop_count` = 1.
- `clear_ovf` does not affect FIFO contents.
- `out_instr` = mem[read pointer] when `out_valid`, else 0.
- `out_valid` and `almost_full` are derived combinationally from the registered `count`.

## Timing

- Reset (`reset_n` low, effective immediately):
  - pointers, `count`, `overflow` and `drop_count` = 0
  - `out_valid` = 0, `almost_full` = 0, `out_instr` = 0
  - Memory contents need not be cleared.
- Reset asserted mid-stream discards all buffered words.
- The first edge after `reset_n` rises operates normally.
- Upstream timing:
  - The router updates `check` and `in_instr` on the falling edge.
  - This block samples on the rising edge, half a cycle later.
  - No synchronizer is required.
- Latency:
  - A word pushed at edge N is visible on `out_valid` / `out_instr` immediately after edge N.
  - It can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained. There is no bubble at full or empty.
- `count`, `almost_full`, `overflow` and `drop_count` all reflect the edge just completed.
- There is no upstream backpressure. `almost_full` is advisory, for software or the issuing node.

## Test plan

- **Reset:** hold `reset_n` = 0 mid-cycle with `check` toggling.
  - Expect all outputs 0 asynchronously.
  - After release, push 0xDEADBEEF: `out_valid` = 1, `out_instr` = 0xDEADBEEF, `count` = 1.
- **Ordering:** push 0x1, 0x2, 0x3 on consecutive cycles with `out_ready` = 0.
  - Expect `count` = 3 and `almost_full` = 1.
  - Then `out_ready` = 1 for 3 cycles: expect `out_instr` sequence 0x1, 0x2, 0x3, then `out_valid` = 0 and `out_instr` = 0.
- **Overflow:** with `depth` = 4, push 6 words without popping.
  - Expect `count` = 4, `overflow` = 1, `drop_count` = 2.
  - Pop 4: expect the first 4 words only.
  - Pulse `clear_ovf`: expect `overflow` = 0, `drop_count` = 0.
- **Full with push and pop:** at `count` = 4, push 0xAA while popping for 8 cycles with incrementing data.
  - Expect `count` to stay at 4, no drops, output order preserved, pointers wrap twice.
- **Idle input:** drive `check` = 0 and `in_instr` = Z for 10 cycles, then `check` = X for 1 cycle.
  - Expect no pushes and `count` = 0.
- **Saturation and clear-vs-drop:** fill the FIFO, push 300 more.
  - Expect `drop_count` = 255.
  - Then `clear_ovf` together with one more dropped push: expect `drop_count` = 1, `overflow` = 1.

Source files
------------

// File: rtl/link_rx_buffer.sv
// link_rx_buffer: receive-side first-word-fall-through FIFO for one link
// of the instruction interconnect. Words that arrive while the FIFO is full
// are discarded, and the sticky overflow flag and saturating drop counter
// record the loss.
module link_rx_buffer #(
    parameter int width       = 32,
    parameter int depth       = 4,
    parameter int afull_level = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   check,
    input  logic [width-1:0]       in_instr,
    input  logic                   out_ready,
    input  logic                   clear_ovf,
    output logic                   out_valid,
    output logic [width-1:0]       out_instr,
    output logic [$clog2(depth):0] count,
    output logic                   almost_full,
    output logic                   overflow,
    output logic [7:0]             drop_count
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    // A pop at the same edge frees a slot, so a full FIFO still accepts
    // the incoming word. Only a full FIFO with no pop drops the word.
    assign full        = (count == CW'(depth));
    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    assign push        = check && (!full || pop);
    assign drop        = check && full && !pop;
    assign almost_full = (count >= CW'(afull_level));
    assign out_instr   = out_valid ? mem[rd_ptr] : '0;

    // Storage write. The memory is not reset, because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Pointers and occupancy. The pointers wrap naturally because depth is
    // a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Drop bookkeeping. A drop in the same cycle as a clear wins, so the
    // lost word is never forgotten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_ovf) begin
                drop_count <= 8'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_link_rx_buffer.sv
// Testbench for link_rx_buffer. A queue-based reference model predicts
// every output after each rising edge.
module tb_link_rx_buffer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int VW    = 1 + W + 3 + 1 + 1 + 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         check = 1'b0;
    logic [W-1:0] in_instr = '0;
    logic         out_ready = 1'b0;
    logic         clear_ovf = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_instr;
    logic [2:0]   count;
    logic         almost_full;
    logic         overflow;
    logic [7:0]   drop_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0;
    int           m_drops = 0;

    link_rx_buffer #(.width(W), .depth(DEPTH), .afull_level(AF)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .check(check),
        .in_instr(in_instr),
        .out_ready(out_ready),
        .clear_ovf(clear_ovf),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .count(count),
        .almost_full(almost_full),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] exp_vec();
        logic [W-1:0] head;
        int n;
        n = mq.size();
        head = (n != 0) ? mq[0] : '0;
        return {n != 0, head, 3'(n), n >= AF, m_ovf, 8'(m_drops)};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {out_valid, out_instr, count, almost_full, overflow, drop_count};
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_drops = 0;
    endfunction

    // Apply one rising edge to the model, using the inputs sampled at that edge.
    function automatic void model_edge(input logic chk, input logic [W-1:0] d,
                                       input logic rdy, input logic clr);
        bit pop;
        bit psh;
        bit drp;
        pop = (mq.size() != 0) && (rdy === 1'b1);
        psh = (chk === 1'b1);
        drp = psh && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (psh && !drp) mq.push_back(d);
        if (clr === 1'b1) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        if (drp) begin
            m_ovf = 1'b1;
            if (m_drops != 255) m_drops++;
        end
    endfunction

    // Drive inputs on the falling edge, as the router does, then settle
    // just after the following rising edge.
    task automatic step(input logic chk, input logic [W-1:0] d,
                        input logic rdy, input logic clr);
        @(negedge clk);
        check = chk;
        in_instr = d;
        out_ready = rdy;
        clear_ovf = clr;
        model_edge(chk, d, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 32'h1111_0000, 1'b0, 1'b0);
        step(1'b1, 32'h2222_0000, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_prefill: got %h expected %h", dut_vec(), exp_vec());
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0", dut_vec());
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check = ~check;
            in_instr = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if (dut_vec() !== '0) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 0", dut_vec());
            end
        end
        @(negedge clk);
        check = 1'b0;
        reset_n = 1'b1;
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'hDEAD_BEEF || count !== 3'd1) begin
            errors++;
            $display("FAIL reset_first_push: got v=%b d=%h c=%0d expected v=1 d=deadbeef c=1",
                     out_valid, out_instr, count);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_drain: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_ordering();
        for (int i = 1; i <= 3; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL order_fill: got c=%0d af=%b expected c=3 af=1", count, almost_full);
        end
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_instr !== W'(i)) begin
                errors++;
                $display("FAIL order_head: got v=%b d=%h expected v=1 d=%h", out_valid, out_instr, W'(i));
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0 || out_instr !== '0 || count !== 3'd0) begin
            errors++;
            $display("FAIL order_empty: got v=%b d=%h c=%0d expected 0 0 0", out_valid, out_instr, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA000_0000 + W'(i), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL ovf_fill: got c=%0d o=%b dc=%0d expected c=4 o=1 dc=2", count, overflow, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_instr !== 32'hA000_0000 + W'(i)) begin
                errors++;
                $display("FAIL ovf_order: got %h expected %h", out_instr, 32'hA000_0000 + W'(i));
            end
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got o=%b dc=%0d v=%b expected 0 0 0", overflow, drop_count, out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + W'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'hAA + W'(i), 1'b1, 1'b0);
            checks++;
            if (count !== 3'd4 || overflow !== 1'b0 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_pushpop: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL full_drain: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) step(1'b0, 'z, $urandom_range(0, 1) == 1, 1'b0);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_z: got c=%0d v=%b expected 0 0", count, out_valid);
        end
        step(1'bx, 32'h5555_5555, 1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL idle_x: got %h expected %h", dut_vec(), exp_vec());
        end
        while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        step(1'b0, '0, 1'b0, 1'b1);
        while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4 + 300; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat_step[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (drop_count !== 8'd255 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_value: got dc=%0d o=%b expected dc=255 o=1", drop_count, overflow);
        end
        step(1'b1, 32'hCAFE_0001, 1'b0, 1'b1);
        checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL clear_vs_drop: got dc=%0d o=%b c=%0d expected dc=1 o=1 c=4",
                     drop_count, overflow, count);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sat_drain: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL initial_reset: got %h expected 0", dut_vec());
        end
        @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_idle();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
